// File: rtl/demod_sequencer.sv
// demod_sequencer: run controller for the I/Q rotation multiplier.
// Latches the demod config on ARM, then drives one phase word per lane
// for exactly sample_length beats and tags the multiplier output valid.
module demod_sequencer #(
   parameter int unsigned LANES      = 5,
   parameter int unsigned PHASE_W    = 14,
   parameter int unsigned STEP_10MHZ = 328,
   parameter int unsigned MULT_LAT   = 2
) (
   input  logic                     i_clk100,
   input  logic                     i_reset,
   input  logic                     i_start_collect,
   input  logic                     i_abort,
   input  logic [3:0]               i_demod_freq,
   input  logic [10:0]              i_sample_length,
   output logic [LANES*PHASE_W-1:0] o_phase_vals,
   output logic                     o_phase_valid,
   output logic                     o_rot_valid,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [10:0]              o_beat_count
);

   typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} state_t;

   state_t                   r_state;
   logic [10:0]              r_len;
   logic [PHASE_W-1:0]       r_inc;
   logic [PHASE_W-1:0]       r_base;
   logic [LANES*PHASE_W-1:0] r_phase_vals;
   logic                     r_phase_valid;
   logic                     r_busy;
   logic                     r_done;
   logic [10:0]              r_beat_count;
   logic [MULT_LAT-1:0]      r_rot_sr;

   logic [PHASE_W-1:0]       w_arm_inc;
   logic [PHASE_W-1:0]       w_cur_base;
   logic [PHASE_W-1:0]       w_cur_inc;
   logic [PHASE_W-1:0]       w_next_base;
   logic [LANES*PHASE_W-1:0] w_lanes;

   // Product wraps naturally at PHASE_W bits (modulo full circle)
   assign w_arm_inc = PHASE_W'(i_demod_freq) * PHASE_W'(STEP_10MHZ);

   // Lane phases for the beat issued at the coming edge; the ARM edge issues
   // beat 1 from base 0 using the increment computed from the live config.
   always_comb begin
      w_lanes = '0;
      if (r_state == StArm) begin
         w_cur_base = '0;
         w_cur_inc  = w_arm_inc;
      end else begin
         w_cur_base = r_base;
         w_cur_inc  = r_inc;
      end
      w_next_base = w_cur_base + PHASE_W'(LANES) * w_cur_inc;
      for (int k = 0; k < LANES; k++) begin
         w_lanes[k*PHASE_W +: PHASE_W] = w_cur_base + PHASE_W'(k) * w_cur_inc;
      end
   end

   // Sequencer FSM with registered outputs
   always_ff @(posedge i_clk100) begin
      if (i_reset) begin
         r_state       <= StIdle;
         r_len         <= '0;
         r_inc         <= '0;
         r_base        <= '0;
         r_phase_vals  <= '0;
         r_phase_valid <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_beat_count  <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               r_done <= 1'b0;
               if (i_start_collect) begin
                  r_state      <= StArm;
                  r_busy       <= 1'b1;
                  r_beat_count <= '0;
                  r_base       <= '0;
               end
            end
            StArm: begin
               if (i_abort) begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
               end else begin
                  r_len <= i_sample_length;
                  r_inc <= w_arm_inc;
                  if (i_sample_length == '0) begin
                     r_state <= StDone;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state       <= StRun;
                     r_phase_valid <= 1'b1;
                     r_phase_vals  <= w_lanes;
                     r_base        <= w_next_base;
                     r_beat_count  <= 11'd1;
                  end
               end
            end
            StRun: begin
               // abort wins over the length-reached transition
               if (i_abort) begin
                  r_state       <= StIdle;
                  r_phase_valid <= 1'b0;
                  r_busy        <= 1'b0;
               end else if (r_beat_count == r_len) begin
                  r_state       <= StDone;
                  r_phase_valid <= 1'b0;
                  r_done        <= 1'b1;
                  r_busy        <= 1'b0;
               end else begin
                  r_phase_vals <= w_lanes;
                  r_base       <= w_next_base;
                  r_beat_count <= r_beat_count + 11'd1;
               end
            end
            StDone: begin
               r_done  <= 1'b0;
               r_state <= StIdle;
            end
            default: begin
               r_state       <= StIdle;
               r_phase_valid <= 1'b0;
               r_busy        <= 1'b0;
               r_done        <= 1'b0;
            end
         endcase
      end
   end

   // Valid pipeline matched to the multiplier latency; drains through aborts
   always_ff @(posedge i_clk100) begin
      if (i_reset) begin
         r_rot_sr <= '0;
      end else begin
         r_rot_sr <= (r_rot_sr << 1) | MULT_LAT'(r_phase_valid);
      end
   end

   assign o_phase_vals  = r_phase_vals;
   assign o_phase_valid = r_phase_valid;
   assign o_rot_valid   = r_rot_sr[MULT_LAT-1];
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_beat_count  = r_beat_count;

endmodule

// File: tb/tb_demod_sequencer.sv
// Self-checking bench for demod_sequencer: scoreboard of expected lane
// phases per beat plus directed checks of timing, abort and reset.
module tb_demod_sequencer;

   localparam int LANES   = 5;
   localparam int PHASE_W = 14;
   localparam int STEP    = 328;
   localparam int FULL    = 16384;

   logic                     clk100 = 1'b0;
   logic                     reset;
   logic                     start_collect;
   logic                     abort;
   logic [3:0]               demod_freq;
   logic [10:0]              sample_length;
   logic [LANES*PHASE_W-1:0] phase_vals;
   logic                     phase_valid;
   logic                     rot_valid;
   logic                     busy;
   logic                     done;
   logic [10:0]              beat_count;

   demod_sequencer dut (
      .i_clk100        (clk100),
      .i_reset         (reset),
      .i_start_collect (start_collect),
      .i_abort         (abort),
      .i_demod_freq    (demod_freq),
      .i_sample_length (sample_length),
      .o_phase_vals    (phase_vals),
      .o_phase_valid   (phase_valid),
      .o_rot_valid     (rot_valid),
      .o_busy          (busy),
      .o_done          (done),
      .o_beat_count    (beat_count)
   );

   always #5 clk100 = ~clk100;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   int pv_total = 0;
   int rot_total = 0;
   logic [LANES*PHASE_W-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference lane phases for beat b (0-based) of a run at frequency f
   function automatic logic [LANES*PHASE_W-1:0] exp_lanes(input int f, input int b);
      logic [LANES*PHASE_W-1:0] v;
      int inc;
      int base;
      inc  = (f * STEP) % FULL;
      base = (b * LANES * inc) % FULL;
      for (int k = 0; k < LANES; k++) begin
         v[k*PHASE_W +: PHASE_W] = PHASE_W'((base + k * inc) % FULL);
      end
      return v;
   endfunction

   task automatic push_run(input int f, input int len);
      for (int b = 0; b < len; b++) exp_q.push_back(exp_lanes(f, b));
   endtask

   // Monitor: scoreboard pops on phase_valid, rot_valid against a 2-deep history
   initial begin
      logic h1, h2;
      h1 = 1'b0;
      h2 = 1'b0;
      forever begin
         @(negedge clk100);
         if (reset) begin
            h1 = 1'b0;
            h2 = 1'b0;
         end else begin
            if (phase_valid) begin
               pv_total++;
               if (exp_q.size() == 0) check_eq("sb_unexpected_beat", 80'd1, 80'd0);
               else check_eq("sb_phase_vals", 80'(phase_vals), 80'(exp_q.pop_front()));
            end
            if (rot_valid || h2) check_eq("rot_valid", 80'(rot_valid), 80'(h2));
            if (rot_valid) rot_total++;
            if (done) done_cnt++;
            h2 = h1;
            h1 = phase_valid;
         end
      end
   end

   task automatic step();
      @(negedge clk100);
      #1;
   endtask

   task automatic wait_pv(input int budget);
      int n = 0;
      while (!phase_valid && n < budget) begin
         step();
         n++;
      end
      if (!phase_valid) check_eq("pv_timeout", 80'd0, 80'd1);
   endtask

   task automatic wait_done(input int budget, input logic exp_prev_pv);
      int n = 0;
      logic prev;
      prev = phase_valid;
      while (!done && n < budget) begin
         prev = phase_valid;
         step();
         n++;
      end
      if (!done) check_eq("done_timeout", 80'd0, 80'd1);
      else check_eq("pv_before_done", 80'(prev), 80'(exp_prev_pv));
   endtask

   task automatic start_pulse(input logic [3:0] f, input logic [10:0] len);
      demod_freq    = f;
      sample_length = len;
      start_collect = 1'b1;
      step();
      start_collect = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, r0, p0, n;
      reset = 1'b1;
      start_collect = 1'b0;
      abort = 1'b0;
      demod_freq = '0;
      sample_length = '0;
      repeat (3) step();
      reset = 1'b0;
      step();
      check_eq("rst_phase_vals", 80'(phase_vals), 80'd0);
      check_eq("rst_flags", 80'({phase_valid, rot_valid, busy, done}), 80'd0);
      check_eq("rst_beat_count", 80'(beat_count), 80'd0);

      // Main run: freq 5, 3 beats, base wraps on beat 2
      push_run(5, 3);
      start_pulse(4'd5, 11'd3);
      check_eq("arm_busy", 80'(busy), 80'd1);
      check_eq("arm_no_pv", 80'(phase_valid), 80'd0);
      step();
      check_eq("first_pv_latency", 80'(phase_valid), 80'd1);
      check_eq("first_beat_count", 80'(beat_count), 80'd1);
      wait_done(20, 1'b1);
      check_eq("main_beat_count", 80'(beat_count), 80'd3);
      check_eq("main_busy_done", 80'(busy), 80'd0);
      step();
      check_eq("done_one_cycle", 80'(done), 80'd0);
      repeat (3) step();
      check_eq("main_sb_empty", 80'(exp_q.size()), 80'd0);

      // Zero-length run
      p0 = pv_total;
      r0 = rot_total;
      start_pulse(4'd4, 11'd0);
      wait_done(10, 1'b0);
      check_eq("len0_beat_count", 80'(beat_count), 80'd0);
      repeat (4) step();
      check_eq("len0_no_pv", 80'(pv_total - p0), 80'd0);
      check_eq("len0_no_rot", 80'(rot_total - r0), 80'd0);

      // Back-to-back runs with start held high
      r0 = rot_total;
      push_run(3, 2);
      push_run(3, 2);
      demod_freq = 4'd3;
      sample_length = 11'd2;
      start_collect = 1'b1;
      wait_done(20, 1'b1);
      n = 0;
      while (!phase_valid && n < 10) begin
         step();
         n++;
      end
      check_eq("b2b_restart_gap", 80'(n), 80'd3);
      wait_done(20, 1'b1);
      start_collect = 1'b0;
      repeat (5) step();
      check_eq("b2b_sb_empty", 80'(exp_q.size()), 80'd0);
      check_eq("b2b_rot_pulses", 80'(rot_total - r0), 80'd4);
      check_eq("b2b_idle", 80'(busy), 80'd0);

      // Abort on the 2nd beat of a 10-beat run
      d0 = done_cnt;
      r0 = rot_total;
      push_run(7, 2);
      start_pulse(4'd7, 11'd10);
      wait_pv(10);
      step();
      check_eq("abort_at_beat2", 80'(beat_count), 80'd2);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_eq("abort_pv", 80'(phase_valid), 80'd0);
      check_eq("abort_busy", 80'(busy), 80'd0);
      check_eq("abort_beat_count", 80'(beat_count), 80'd2);
      repeat (4) step();
      check_eq("abort_no_done", 80'(done_cnt - d0), 80'd0);
      check_eq("abort_rot_drain", 80'(rot_total - r0), 80'd2);
      check_eq("abort_sb_empty", 80'(exp_q.size()), 80'd0);

      // Config changes mid-run are ignored
      push_run(2, 6);
      start_pulse(4'd2, 11'd6);
      wait_pv(10);
      demod_freq = 4'd9;
      sample_length = 11'd3;
      wait_done(30, 1'b1);
      check_eq("midrun_beat_count", 80'(beat_count), 80'd6);
      repeat (3) step();
      check_eq("midrun_sb_empty", 80'(exp_q.size()), 80'd0);

      // Reset while running
      d0 = done_cnt;
      push_run(1, 20);
      start_pulse(4'd1, 11'd20);
      wait_pv(10);
      repeat (2) step();
      reset = 1'b1;
      step();
      check_eq("rrun_phase_vals", 80'(phase_vals), 80'd0);
      check_eq("rrun_flags", 80'({phase_valid, rot_valid, busy, done}), 80'd0);
      check_eq("rrun_beat_count", 80'(beat_count), 80'd0);
      reset = 1'b0;
      exp_q.delete();
      step();
      check_eq("rrun_rot_empty1", 80'(rot_valid), 80'd0);
      step();
      check_eq("rrun_rot_empty2", 80'({rot_valid, phase_valid, busy}), 80'd0);
      check_eq("rrun_no_done", 80'(done_cnt - d0), 80'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
